pwm_capture_16bits: RTL
=======================

Name: pwm_capture_16bits

Overview:
- Input-capture block: the receiving end of the PWM outputs driven by the carrier/compare/dead-time generator.
- Samples an external complementary pulse pair (A/B) and measures the period and high time of A, and the dead time from A falling to B rising.
- Results are in prescaled clock ticks. They are presented to the register bank with a one-cycle valid strobe and an optional interrupt.
- Used for loop-back verification of the PWM unit and for measuring external gate signals.

Parameters:
CNT_WIDTH, 16, width of the measurement counters and result registers
DIV_WIDTH, 4, width of the prescaler divide value
SYNC_STAGES, 2, flip-flop stages in the input synchronizers (min 2)

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous active-low reset, sampled on rising edge of clk
cap_onoff  input  1  1 = capture enabled, 0 = capture idle
clkdiv  input  DIV_WIDTH  prescaler value D; one tick every D+1 clk cycles
clkdiv_onoff  input  1  1 = prescaler active, 0 = tick every clk
int_onoff  input  1  interrupt enable
pwm_in_A  input  1  asynchronous PWM input A
pwm_in_B  input  1  asynchronous PWM input B
period_out  output  CNT_WIDTH  A rise-to-rise time, in ticks
hightime_out  output  CNT_WIDTH  A rise-to-fall time, in ticks
deadtime_out  output  CNT_WIDTH  A fall to first subsequent B rise, in ticks
dead_valid  output  1  1 = a B rise was seen in the last measured period
valid  output  1  one-cycle strobe; all result registers are updated
overflow  output  1  sticky; a counter saturated before the closing edge
interrupt  output  1  registered; valid AND int_onoff

Behaviour:
- Reset (reset=0 at a clk edge): all outputs, counters, synchronizers and the FSM go to 0 / IDLE.
- Synchronizers: A and B each pass through SYNC_STAGES FFs plus one edge register. An edge is detected SYNC_STAGES+1 cycles after the pin transition. Both paths have identical latency, so it cancels in all measurements.
- Prescaler:
  - clkdiv_onoff=0: tick every cycle.
  - clkdiv_onoff=1: divcnt counts 0..D and ticks when divcnt==D.
  - divcnt restarts at 0 on every detected A edge.
  - D=0 is equivalent to prescaler off.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: waits for cap_onoff=1, then goes to ARM.
  - From any state, cap_onoff=0 returns to IDLE on the next edge. Result registers hold; valid/interrupt are forced to 0.
  - ARM: waits for an A rising edge (a partial first period is discarded). On the edge: cnt<=1 (prescaler off) or cnt<=0 (prescaler on); go to HIGH.
  - HIGH: cnt increments per tick. On A fall: hlat<=cnt, dcnt cleared, dseen<=0; go to LOW.
  - LOW: cnt and dcnt increment per tick. On the first B rise: dlat<=dcnt, dseen<=1. Later B rises in the same period are ignored.
  - LOW, on A rise:
    - period_out<=cnt, hightime_out<=hlat, deadtime_out<=dlat (if dseen, else held), dead_valid<=dseen.
    - valid=1 for exactly one cycle; overflow<=0.
    - Restart cnt as in ARM; go to HIGH.
- Resolution:
  - Prescaler off: exact clk cycles.
  - Prescaler on: floor(cycles/(D+1)) within ±1 tick.
- Overflow: cnt or dcnt reaching all-ones (saturates, never wraps) sets overflow=1. The FSM goes to ARM, no valid is issued, and results hold. overflow clears only on the next valid.
- Same-cycle events:
  - A edge and B rise in the same cycle: the A edge is processed first. A B rise coincident with an A fall counts as dead time 0 (dlat<=0, dseen<=1).
  - Coincident with an A rise, the B rise is ignored.
- interrupt is asserted the cycle after valid when int_onoff=1, for one cycle.

Test Plan:
- Reset mid-measurement: reset=0 for 1 cycle while in LOW with cnt=37 -> all outputs 0, FSM in IDLE, no valid until a full new period.
- Prescaler off, A period 200 cycles, high 80; B rises 10 cycles after A falls -> after the 2nd A rise: valid pulse, period_out=200, hightime_out=80, deadtime_out=10, dead_valid=1; identical values every subsequent period.
- Prescaler on, D=3, A period 400 / high 100 -> period_out=100±1, hightime_out=25±1.
- B held low entire run -> dead_valid=0, deadtime_out stays 0.
- A stuck high after the first rise, prescaler off -> overflow=1 after 65535 cycles, no valid; restore 200-cycle PWM -> first valid clears overflow.
- int_onoff=1 -> interrupt 1-cycle pulse one clk after each valid; int_onoff=0 -> interrupt never asserted. cap_onoff dropped mid-period -> no valid, results held.

Source files
------------

// File: rtl/pwm_capture_16bits.sv
//------------------------------------------------------------------------------
// Module      : pwm_capture_16bits
// Description : Input capture for a complementary PWM pair. Measures period,
//               high time and A-fall to B-rise dead time in prescaled ticks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_capture_16bits #(
    parameter int CNT_WIDTH   = 16,
    parameter int DIV_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cap_onoff,
    input  logic [DIV_WIDTH-1:0] clkdiv,
    input  logic                 clkdiv_onoff,
    input  logic                 int_onoff,
    input  logic                 pwm_in_A,
    input  logic                 pwm_in_B,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] hightime_out,
    output logic [CNT_WIDTH-1:0] deadtime_out,
    output logic                 dead_valid,
    output logic                 valid,
    output logic                 overflow,
    output logic                 interrupt
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_HIGH = 2'd2;
    localparam logic [1:0] c_LOW  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_a_sync;
    logic [SYNC_STAGES-1:0] r_b_sync;
    logic                   r_a_d;
    logic                   r_b_d;

    logic [DIV_WIDTH-1:0]   r_divcnt;
    logic [1:0]             r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_dcnt;
    logic [CNT_WIDTH-1:0]   r_hlat;
    logic [CNT_WIDTH-1:0]   r_dlat;
    logic                   r_dseen;

    logic [CNT_WIDTH-1:0]   r_period;
    logic [CNT_WIDTH-1:0]   r_hightime;
    logic [CNT_WIDTH-1:0]   r_deadtime;
    logic                   r_dead_valid;
    logic                   r_valid;
    logic                   r_overflow;
    logic                   r_interrupt;

    logic                   w_a_s;
    logic                   w_b_s;
    logic                   w_a_rise;
    logic                   w_a_fall;
    logic                   w_b_rise;
    logic                   w_tick;
    logic [CNT_WIDTH-1:0]   w_restart;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic [CNT_WIDTH-1:0]   w_dcnt_inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
            r_a_d    <= 1'b0;
            r_b_d    <= 1'b0;
        end else begin
            r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], pwm_in_A};
            r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], pwm_in_B};
            r_a_d    <= r_a_sync[SYNC_STAGES-1];
            r_b_d    <= r_b_sync[SYNC_STAGES-1];
        end
    end

    assign w_a_s    = r_a_sync[SYNC_STAGES-1];
    assign w_b_s    = r_b_sync[SYNC_STAGES-1];
    assign w_a_rise = w_a_s & ~r_a_d;
    assign w_a_fall = ~w_a_s & r_a_d;
    assign w_b_rise = w_b_s & ~r_b_d;

    assign w_tick = !clkdiv_onoff || (r_divcnt == clkdiv);

    // Starting at 1 when every cycle is a tick makes the counts exact;
    // with a real divider the first tick arrives D+1 cycles after the edge.
    assign w_restart  = (clkdiv_onoff && (clkdiv != '0)) ? '0 : {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign w_cnt_inc  = (w_tick && (r_cnt  != c_CNT_MAX)) ? r_cnt  + 1'b1 : r_cnt;
    assign w_dcnt_inc = (w_tick && (r_dcnt != c_CNT_MAX)) ? r_dcnt + 1'b1 : r_dcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_divcnt <= '0;
        end else if (w_a_rise || w_a_fall || !clkdiv_onoff || (r_divcnt == clkdiv)) begin
            r_divcnt <= '0;
        end else begin
            r_divcnt <= r_divcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_dcnt       <= '0;
            r_hlat       <= '0;
            r_dlat       <= '0;
            r_dseen      <= 1'b0;
            r_period     <= '0;
            r_hightime   <= '0;
            r_deadtime   <= '0;
            r_dead_valid <= 1'b0;
            r_valid      <= 1'b0;
            r_overflow   <= 1'b0;
            r_interrupt  <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_interrupt <= cap_onoff & r_valid & int_onoff;
            if (!cap_onoff) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: r_state <= c_ARM;
                    c_ARM: begin
                        if (w_a_rise) begin
                            r_cnt   <= w_restart;
                            r_state <= c_HIGH;
                        end
                    end
                    c_HIGH: begin
                        if (w_a_fall) begin
                            r_hlat  <= r_cnt;
                            r_cnt   <= w_cnt_inc;
                            r_dcnt  <= w_restart;
                            // A B rise coincident with the A fall is zero dead time
                            r_dlat  <= '0;
                            r_dseen <= w_b_rise;
                            r_state <= c_LOW;
                        end else if (r_cnt == c_CNT_MAX) begin
                            r_overflow <= 1'b1;
                            r_state    <= c_ARM;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    c_LOW: begin
                        if (w_a_rise) begin
                            r_period     <= r_cnt;
                            r_hightime   <= r_hlat;
                            if (r_dseen) r_deadtime <= r_dlat;
                            r_dead_valid <= r_dseen;
                            r_valid      <= 1'b1;
                            r_overflow   <= 1'b0;
                            r_cnt        <= w_restart;
                            r_state      <= c_HIGH;
                        end else if ((r_cnt == c_CNT_MAX) || (r_dcnt == c_CNT_MAX)) begin
                            r_overflow <= 1'b1;
                            r_state    <= c_ARM;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_dcnt <= w_dcnt_inc;
                            if (w_b_rise && !r_dseen) begin
                                r_dlat  <= r_dcnt;
                                r_dseen <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign period_out   = r_period;
    assign hightime_out = r_hightime;
    assign deadtime_out = r_deadtime;
    assign dead_valid   = r_dead_valid;
    assign valid        = r_valid;
    assign overflow     = r_overflow;
    assign interrupt    = r_interrupt;

endmodule

`default_nettype wire
